// File: rtl/regfile_wb_merge.sv
// Write-back merge: two buffered val/rdy streams onto the single regfile port.
// in0 has priority; in1 is force-granted after p_max_wait consecutive losses.
module regfile_wb_merge #(
    parameter int p_data_nbits  = 32,
    parameter int p_num_entries = 32,
    parameter int p_max_wait    = 4,
    parameter bit p_zero_reg_en = 1'b1,
    localparam int c_addr_nbits = $clog2(p_num_entries)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in0_val,
    output logic                    in0_rdy,
    input  logic [c_addr_nbits-1:0] in0_addr,
    input  logic [p_data_nbits-1:0] in0_data,
    input  logic                    in1_val,
    output logic                    in1_rdy,
    input  logic [c_addr_nbits-1:0] in1_addr,
    input  logic [p_data_nbits-1:0] in1_data,
    output logic                    write_en,
    output logic [c_addr_nbits-1:0] write_addr,
    output logic [p_data_nbits-1:0] write_data,
    input  logic [c_addr_nbits-1:0] query_addr,
    output logic                    query_hit
);

    localparam int c_wait_nbits = $clog2(p_max_wait + 1);
    localparam logic [c_wait_nbits-1:0] c_max_wait = c_wait_nbits'(p_max_wait);

    logic [c_addr_nbits-1:0] q_addr [2][2];
    logic [p_data_nbits-1:0] q_data [2][2];
    logic [1:0]              cnt    [2];
    logic [1:0]              wptr;
    logic [1:0]              rptr;

    logic [1:0]              in_val;
    logic [c_addr_nbits-1:0] in_addr [2];
    logic [p_data_nbits-1:0] in_data [2];
    logic [1:0]              rdy;
    logic [1:0]              push;
    logic [1:0]              pop;
    logic [1:0]              head_v;
    logic [c_addr_nbits-1:0] head_addr [2];
    logic [p_data_nbits-1:0] head_data [2];

    logic                    grant0;
    logic                    grant1;
    logic                    hit;
    logic [c_wait_nbits-1:0] wait_cnt;

    assign in_val     = {in1_val, in0_val};
    assign in_addr[0] = in0_addr;
    assign in_addr[1] = in1_addr;
    assign in_data[0] = in0_data;
    assign in_data[1] = in1_data;
    assign in0_rdy    = rdy[0];
    assign in1_rdy    = rdy[1];

    always_comb begin
        for (int s = 0; s < 2; s++) begin
            head_v[s]    = (cnt[s] != 2'd0);
            rdy[s]       = reset && (cnt[s] < 2'd2);
            push[s]      = in_val[s] && rdy[s];
            head_addr[s] = q_addr[s][rptr[s]];
            head_data[s] = q_data[s][rptr[s]];
        end
    end

    // in1 wins a contested cycle only once its wait budget is exhausted
    always_comb begin
        grant1 = head_v[1] && (!head_v[0] || wait_cnt == c_max_wait);
        grant0 = head_v[0] && !grant1;
        pop    = {grant1, grant0};
    end

    always_comb begin
        write_addr = grant1 ? head_addr[1] : head_addr[0];
        write_data = grant1 ? head_data[1] : head_data[0];
        write_en   = reset && (grant0 || grant1)
                     && !(p_zero_reg_en && write_addr == '0);
    end

    // popping entries still count; same-cycle pushes do not
    always_comb begin
        hit = 1'b0;
        for (int s = 0; s < 2; s++) begin
            for (int e = 0; e < 2; e++) begin
                if ((cnt[s] == 2'd2 || (cnt[s] == 2'd1 && rptr[s] == 1'(e)))
                    && q_addr[s][e] == query_addr) begin
                    hit = 1'b1;
                end
            end
        end
        query_hit = reset && hit && !(p_zero_reg_en && query_addr == '0);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int s = 0; s < 2; s++) begin
                cnt[s] <= 2'd0;
            end
            wptr <= 2'b00;
            rptr <= 2'b00;
        end else begin
            for (int s = 0; s < 2; s++) begin
                if (push[s]) begin
                    q_addr[s][wptr[s]] <= in_addr[s];
                    q_data[s][wptr[s]] <= in_data[s];
                    wptr[s]            <= ~wptr[s];
                end
                if (pop[s]) begin
                    rptr[s] <= ~rptr[s];
                end
                case ({push[s], pop[s]})
                    2'b10:   cnt[s] <= cnt[s] + 2'd1;
                    2'b01:   cnt[s] <= cnt[s] - 2'd1;
                    default: cnt[s] <= cnt[s];
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (grant1 || !head_v[1]) begin
            wait_cnt <= '0;
        end else if (wait_cnt != c_max_wait) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            assert (!$isunknown(in0_val));
            assert (!$isunknown(in1_val));
            if (in0_val) begin
                assert (!$isunknown(in0_addr) && int'(in0_addr) < p_num_entries);
            end
            if (in1_val) begin
                assert (!$isunknown(in1_addr) && int'(in1_addr) < p_num_entries);
            end
            if (write_en) begin
                assert (int'(write_addr) < p_num_entries);
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_merge.sv
// Directed bench for regfile_wb_merge with default parameters
// (p_max_wait=4, zero register suppressed).
module tb_regfile_wb_merge;

    logic        clk;
    logic        reset;
    logic        in0_val;
    logic        in0_rdy;
    logic [4:0]  in0_addr;
    logic [31:0] in0_data;
    logic        in1_val;
    logic        in1_rdy;
    logic [4:0]  in1_addr;
    logic [31:0] in1_data;
    logic        write_en;
    logic [4:0]  write_addr;
    logic [31:0] write_data;
    logic [4:0]  query_addr;
    logic        query_hit;

    int vectors;
    int miscompares;

    regfile_wb_merge dut (
        .clk        (clk),
        .reset      (reset),
        .in0_val    (in0_val),
        .in0_rdy    (in0_rdy),
        .in0_addr   (in0_addr),
        .in0_data   (in0_data),
        .in1_val    (in1_val),
        .in1_rdy    (in1_rdy),
        .in1_addr   (in1_addr),
        .in1_data   (in1_data),
        .write_en   (write_en),
        .write_addr (write_addr),
        .write_data (write_data),
        .query_addr (query_addr),
        .query_hit  (query_hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        in0_val  = 1'b1;
        in0_addr = 5'd1;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if (in0_rdy !== 1'b0) begin
                $display("FAIL reset_in0_rdy: got %b want 0", in0_rdy);
                miscompares++;
            end
            vectors++;
            if (in1_rdy !== 1'b0) begin
                $display("FAIL reset_in1_rdy: got %b want 0", in1_rdy);
                miscompares++;
            end
            vectors++;
            if (write_en !== 1'b0) begin
                $display("FAIL reset_write_en: got %b want 0", write_en);
                miscompares++;
            end
        end
        reset      = 1'b1;
        in0_val    = 1'b0;
        query_addr = 5'd5;
        #1;
        vectors++;
        if (in0_rdy !== 1'b1 || in1_rdy !== 1'b1) begin
            $display("FAIL release_rdy: got %b%b want 11", in0_rdy, in1_rdy);
            miscompares++;
        end
        vectors++;
        if (query_hit !== 1'b0) begin
            $display("FAIL release_query: got %b want 0", query_hit);
            miscompares++;
        end
    endtask

    task automatic test_single();
        in0_val  = 1'b1;
        in0_addr = 5'd5;
        in0_data = 32'hDEADBEEF;
        step();
        in0_val = 1'b0;
        #1;
        vectors++;
        if (write_en !== 1'b1 || write_addr !== 5'd5
            || write_data !== 32'hDEADBEEF) begin
            $display("FAIL single_write: got en=%b a=%0d d=%h want en=1 a=5 d=deadbeef",
                     write_en, write_addr, write_data);
            miscompares++;
        end
        step();
        vectors++;
        if (write_en !== 1'b0) begin
            $display("FAIL single_idle: got en=%b want 0", write_en);
            miscompares++;
        end
    endtask

    task automatic test_starve();
        in0_val  = 1'b1;
        in0_addr = 5'd1;
        in1_val  = 1'b1;
        in1_addr = 5'd7;
        in1_data = 32'h77;
        step();
        in1_val = 1'b0;
        for (int k = 0; k < 5; k++) begin
            in0_val = (k < 4);
            #1;
            vectors++;
            if (dut.wait_cnt !== 3'(k)) begin
                $display("FAIL starve_wait_%0d: got %0d want %0d", k, dut.wait_cnt, k);
                miscompares++;
            end
            vectors++;
            if (k < 4 && (write_en !== 1'b1 || write_addr !== 5'd1)) begin
                $display("FAIL starve_in0_%0d: got en=%b a=%0d want en=1 a=1",
                         k, write_en, write_addr);
                miscompares++;
            end else if (k == 4 && (write_en !== 1'b1 || write_addr !== 5'd7
                                    || write_data !== 32'h77)) begin
                $display("FAIL starve_grant: got en=%b a=%0d d=%h want en=1 a=7 d=77",
                         write_en, write_addr, write_data);
                miscompares++;
            end
            step();
        end
        in0_val = 1'b0;
        #1;
        vectors++;
        if (dut.wait_cnt !== 3'd0) begin
            $display("FAIL starve_wait_clear: got %0d want 0", dut.wait_cnt);
            miscompares++;
        end
        vectors++;
        if (write_en !== 1'b1 || write_addr !== 5'd1) begin
            $display("FAIL starve_tail: got en=%b a=%0d want en=1 a=1",
                     write_en, write_addr);
            miscompares++;
        end
        step();
        vectors++;
        if (write_en !== 1'b0) begin
            $display("FAIL starve_idle: got en=%b want 0", write_en);
            miscompares++;
        end
    endtask

    task automatic test_backpressure();
        int   idx;
        int   n;
        logic fire;
        logic [4:0] got [8];
        idx = 0;
        n   = 0;
        for (int c = 0; c < 30; c++) begin
            in0_val  = (c < 12);
            in0_addr = 5'd2;
            in0_data = 32'(c);
            in1_val  = (idx < 3);
            in1_addr = 5'(10 + idx);
            in1_data = 32'(100 + idx);
            #1;
            if (c == 2 || c == 5) begin
                vectors++;
                if (in1_rdy !== 1'b0) begin
                    $display("FAIL bp_full_c%0d: got rdy=%b want 0", c, in1_rdy);
                    miscompares++;
                end
            end
            if (c == 5) begin
                vectors++;
                if (write_en !== 1'b1 || write_addr !== 5'd10) begin
                    $display("FAIL bp_forced: got en=%b a=%0d want en=1 a=10",
                             write_en, write_addr);
                    miscompares++;
                end
            end
            if (c == 6) begin
                vectors++;
                if (in1_rdy !== 1'b1) begin
                    $display("FAIL bp_slot_free: got rdy=%b want 1", in1_rdy);
                    miscompares++;
                end
            end
            if (write_en === 1'b1 && write_addr >= 5'd10 && n < 8) begin
                got[n] = write_addr;
                n++;
            end
            fire = in1_val && in1_rdy;
            step();
            if (fire) idx++;
        end
        in0_val = 1'b0;
        in1_val = 1'b0;
        vectors++;
        if (n != 3 || idx != 3) begin
            $display("FAIL bp_count: got writes=%0d pushes=%0d want 3 3", n, idx);
            miscompares++;
        end else begin
            for (int i = 0; i < 3; i++) begin
                vectors++;
                if (got[i] !== 5'(10 + i)) begin
                    $display("FAIL bp_order_%0d: got %0d want %0d", i, got[i], 10 + i);
                    miscompares++;
                end
            end
        end
    endtask

    task automatic test_zero();
        in0_val  = 1'b1;
        in0_addr = 5'd0;
        in0_data = 32'h11;
        step();
        in0_addr   = 5'd3;
        in0_data   = 32'h33;
        query_addr = 5'd0;
        #1;
        vectors++;
        if (write_en !== 1'b0) begin
            $display("FAIL zero_suppress: got en=%b want 0", write_en);
            miscompares++;
        end
        vectors++;
        if (query_hit !== 1'b0) begin
            $display("FAIL zero_query: got %b want 0", query_hit);
            miscompares++;
        end
        step();
        in0_val = 1'b0;
        #1;
        vectors++;
        if (write_en !== 1'b1 || write_addr !== 5'd3 || write_data !== 32'h33) begin
            $display("FAIL zero_next: got en=%b a=%0d d=%h want en=1 a=3 d=33",
                     write_en, write_addr, write_data);
            miscompares++;
        end
        step();
        vectors++;
        if (write_en !== 1'b0) begin
            $display("FAIL zero_idle: got en=%b want 0", write_en);
            miscompares++;
        end
    endtask

    task automatic test_query();
        in0_val  = 1'b1;
        in0_addr = 5'd9;
        in1_val  = 1'b1;
        in1_addr = 5'd12;
        step();
        in0_val    = 1'b0;
        in1_val    = 1'b0;
        query_addr = 5'd12;
        #1;
        vectors++;
        if (query_hit !== 1'b1) begin
            $display("FAIL query_12: got %b want 1", query_hit);
            miscompares++;
        end
        query_addr = 5'd9;
        #1;
        vectors++;
        if (query_hit !== 1'b1) begin
            $display("FAIL query_popping_9: got %b want 1", query_hit);
            miscompares++;
        end
        query_addr = 5'd4;
        #1;
        vectors++;
        if (query_hit !== 1'b0) begin
            $display("FAIL query_4: got %b want 0", query_hit);
            miscompares++;
        end
        step();
        query_addr = 5'd12;
        #1;
        vectors++;
        if (query_hit !== 1'b1 || write_addr !== 5'd12) begin
            $display("FAIL query_12_draining: got hit=%b a=%0d want 1 12",
                     query_hit, write_addr);
            miscompares++;
        end
        step();
        vectors++;
        if (query_hit !== 1'b0) begin
            $display("FAIL query_drained: got %b want 0", query_hit);
            miscompares++;
        end
    endtask

    task automatic test_reset_mid();
        in0_val  = 1'b1;
        in0_addr = 5'd6;
        in1_val  = 1'b1;
        in1_addr = 5'd8;
        step();
        in0_val    = 1'b0;
        in1_val    = 1'b0;
        reset      = 1'b0;
        query_addr = 5'd8;
        #1;
        vectors++;
        if (write_en !== 1'b0 || query_hit !== 1'b0 || in1_rdy !== 1'b0) begin
            $display("FAIL mid_reset_outs: got en=%b hit=%b rdy=%b want 0 0 0",
                     write_en, query_hit, in1_rdy);
            miscompares++;
        end
        step();
        reset = 1'b1;
        #1;
        vectors++;
        if (query_hit !== 1'b0 || write_en !== 1'b0) begin
            $display("FAIL mid_reset_flush: got hit=%b en=%b want 0 0",
                     query_hit, write_en);
            miscompares++;
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        in0_val     = 1'b0;
        in0_addr    = 5'd0;
        in0_data    = 32'd0;
        in1_val     = 1'b0;
        in1_addr    = 5'd0;
        in1_data    = 32'd0;
        query_addr  = 5'd0;
        test_reset();
        test_single();
        test_starve();
        test_backpressure();
        test_zero();
        test_query();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
